// File: rtl/des_core_scheduler.sv
// des_core_scheduler
//   Spreads one seed-search job over NUM_CORES des_block instances. A job is
//   a 64-bit base seed plus a chunk count. Chunk k is started on the
//   lowest-index free core with seed base_seed + k. Each finished core's
//   counter is added into a 64-bit running total, and the core is then
//   restarted so it can be reused.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   job_valid/ready   job handshake; job_base_seed, job_num_chunks describe it
//   abort             cancel the running job (only acted on in RUN)
//   core_start        one-cycle start pulse per core; core_seed valid with it
//   core_restart      one-cycle restart pulse per core
//   core_done         per-core done level
//   core_counter      per-core counters, core i at [i*CNT_W +: CNT_W]
//   busy, done        job in progress / job complete with total valid
//   total_counter     64-bit sum of collected counters (wraps)
//   chunks_done       chunks collected in the current job
module des_core_scheduler #(
   parameter int NUM_CORES = 4,
   parameter int CNT_W     = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       job_valid,
   output logic                       job_ready,
   input  logic [63:0]                job_base_seed,
   input  logic [31:0]                job_num_chunks,
   input  logic                       abort,
   output logic [NUM_CORES-1:0]       core_start,
   output logic [NUM_CORES-1:0]       core_restart,
   output logic [63:0]                core_seed,
   input  logic [NUM_CORES-1:0]       core_done,
   input  logic [NUM_CORES*CNT_W-1:0] core_counter,
   output logic                       busy,
   output logic                       done,
   output logic [63:0]                total_counter,
   output logic [31:0]                chunks_done
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t               state;
   logic [63:0]          base_seed_q;
   logic [31:0]          num_chunks_q;
   logic [31:0]          next_chunk_q;
   // alloc_q: core holds a chunk. release_q: core was collected last cycle
   // and is being restarted; it stays allocated until the next edge so it
   // can neither be re-collected nor re-dispatched while restarting.
   logic [NUM_CORES-1:0] alloc_q;
   logic [NUM_CORES-1:0] release_q;

   logic [NUM_CORES-1:0] free_mask;
   logic [NUM_CORES-1:0] coll_mask;
   logic [NUM_CORES-1:0] disp_onehot;
   logic [NUM_CORES-1:0] coll_onehot;
   logic [CNT_W-1:0]     coll_cnt;
   logic                 dispatch_ok;
   logic                 collect_ok;
   logic [31:0]          chunks_next;

   assign free_mask   = ~alloc_q;
   assign coll_mask   = alloc_q & ~release_q & core_done;
   assign dispatch_ok = (next_chunk_q < num_chunks_q) && (|free_mask);
   assign collect_ok  = |coll_mask;
   assign chunks_next = chunks_done + 32'(collect_ok);

   // Lowest-index pick: scan downward so the last hit is the lowest index.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      disp_onehot = '0;
      coll_onehot = '0;
      coll_cnt    = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (free_mask[i]) begin
            disp_onehot    = '0;
            disp_onehot[i] = 1'b1;
         end
         if (coll_mask[i]) begin
            coll_onehot    = '0;
            coll_onehot[i] = 1'b1;
            coll_cnt       = core_counter[i*CNT_W +: CNT_W];
         end
      end
   end

   // NOTE: all state and registered outputs use non-blocking assignments so
   // every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         base_seed_q   <= '0;
         num_chunks_q  <= '0;
         next_chunk_q  <= '0;
         alloc_q       <= '0;
         release_q     <= '0;
         job_ready     <= 1'b1;
         busy          <= 1'b0;
         done          <= 1'b0;
         core_start    <= '0;
         core_restart  <= '0;
         core_seed     <= '0;
         total_counter <= '0;
         chunks_done   <= '0;
      end else begin
         core_start   <= '0;
         core_restart <= '0;
         alloc_q      <= alloc_q & ~release_q;
         release_q    <= '0;

         case (state)
            IDLE, FINISH: begin
               if (job_valid) begin
                  base_seed_q   <= job_base_seed;
                  num_chunks_q  <= job_num_chunks;
                  next_chunk_q  <= '0;
                  total_counter <= '0;
                  chunks_done   <= '0;
                  done          <= 1'b0;
                  job_ready     <= 1'b0;
                  // An empty job passes through RUN for one cycle, where
                  // the completion check sends it straight to FINISH.
                  busy          <= (job_num_chunks != 32'd0);
                  state         <= RUN;
               end
            end

            RUN: begin
               if (abort) begin
                  core_restart <= alloc_q;
                  alloc_q      <= '0;
                  release_q    <= '0;
                  busy         <= 1'b0;
                  done         <= 1'b0;
                  job_ready    <= 1'b1;
                  state        <= IDLE;
               end else begin
                  if (dispatch_ok) begin
                     core_start   <= disp_onehot;
                     core_seed    <= base_seed_q + 64'(next_chunk_q);
                     next_chunk_q <= next_chunk_q + 32'd1;
                     alloc_q      <= (alloc_q & ~release_q) | disp_onehot;
                  end
                  if (collect_ok) begin
                     total_counter <= total_counter + 64'(coll_cnt);
                     chunks_done   <= chunks_next;
                     core_restart  <= coll_onehot;
                     release_q     <= coll_onehot;
                  end
                  // All chunks collected implies all were dispatched, so
                  // no dispatch can coincide with this transition.
                  if (chunks_next == num_chunks_q) begin
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     job_ready <= 1'b1;
                     state     <= FINISH;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
